// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S frame constants, channel/state enums and helpers
package i2s_pkg;

  // 32-bit stereo frame: two 16-bit channel words, MSB first
  localparam int FRAME_BITS          = 32;
  localparam int SAMPLE_BITS_DEFAULT = 16;

  // Bit counter covers one full frame and saturates at FRAME_BITS-1
  localparam int CNT_W = $clog2(FRAME_BITS);

  // Transmitter side: BCLK = clk/16 at 24.576 MHz gives 1.536 MHz, 512 clk per frame
  localparam int TX_CLK_PER_BCLK  = 16;
  localparam int TX_CLK_PER_FRAME = FRAME_BITS * TX_CLK_PER_BCLK;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } channel_t;

  typedef enum logic {
    ACQUIRE = 1'b0,
    RUN     = 1'b1
  } rx_state_t;

  // Increment that sticks at the top of the frame so an over-long word never wraps
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_W'(FRAME_BITS - 1)) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// rtl/i2s_sync_edge.sv - N-stage synchronizer with rising-edge pulse
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async pin through the chain and remember last synchronized level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S slave receiver producing coherent 16-bit stereo pairs
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_clock,
  input  logic                   word_select,
  input  logic                   sound_data,
  output logic [SAMPLE_BITS-1:0] left_sample,
  output logic [SAMPLE_BITS-1:0] right_sample,
  output logic                   sample_valid,
  output logic                   frame_error,
  output logic                   locked
);

  localparam logic [CNT_W:0] WORD_LEN = (CNT_W + 1)'(SAMPLE_BITS);

  logic                   bclk_rise;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   ws_s;
  logic                   sd_s;

  rx_state_t              state;
  rx_state_t              state_next;
  logic [SAMPLE_BITS-2:0] shift_reg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   ws_prev;
  logic                   left_pending;
  logic [SAMPLE_BITS-1:0] left_hold;

  logic                   toggle;
  logic                   word_ok;
  logic                   word_bad;
  logic [SAMPLE_BITS-1:0] word;
  logic [CNT_W:0]         word_len;

  i2s_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_bclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bit_clock),
    .level(),
    .rise (bclk_rise)
  );

  // WS and SD use the same depth as BCLK so all three stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_sync <= '0;
      sd_sync <= '0;
    end else begin
      ws_sync <= {ws_sync[SYNC_STAGES-2:0], word_select};
      sd_sync <= {sd_sync[SYNC_STAGES-2:0], sound_data};
    end
  end

  assign ws_s = ws_sync[SYNC_STAGES-1];
  assign sd_s = sd_sync[SYNC_STAGES-1];

  // Alignment state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACQUIRE;
    end else begin
      state <= state_next;
    end
  end

  // Detect WS toggles, judge the completed word length and pick the next state
  always_comb begin
    state_next = state;
    toggle     = 1'b0;
    word_ok    = 1'b0;
    word_bad   = 1'b0;
    word       = {shift_reg, sd_s};
    word_len   = {1'b0, bit_cnt} + (CNT_W + 1)'(1);
    if (bclk_rise && (ws_s != ws_prev)) begin
      toggle = 1'b1;
      case (state)
        ACQUIRE: state_next = RUN;
        RUN: begin
          if (word_len == WORD_LEN) begin
            word_ok = 1'b1;
          end else begin
            word_bad = 1'b1;
          end
        end
        default: state_next = ACQUIRE;
      endcase
    end
  end

  // Deserialize on bclk_rise, pair left/right words and raise one-clk strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      ws_prev      <= 1'b0;
      left_pending <= 1'b0;
      left_hold    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      if (bclk_rise) begin
        shift_reg <= word[SAMPLE_BITS-2:0];
        ws_prev   <= ws_s;
        bit_cnt   <= toggle ? '0 : sat_inc(bit_cnt);
      end
      if (word_ok) begin
        if (ws_prev == LEFT) begin
          left_hold    <= word;
          left_pending <= 1'b1;
        end else if (left_pending) begin
          left_sample  <= left_hold;
          right_sample <= word;
          sample_valid <= 1'b1;
          left_pending <= 1'b0;
        end
      end
      if (word_bad) begin
        frame_error  <= 1'b1;
        left_pending <= 1'b0;
      end
    end
  end

  assign locked = (state == RUN);

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - scoreboard bench for i2s_receiver with word-level reference model
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_clock = 1'b0;
  logic        word_select = 1'b0;
  logic        sound_data = 1'b0;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic        frame_error;
  logic        locked;

  i2s_receiver #(
    .SAMPLE_BITS(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bit_clock   (bit_clock),
    .word_select (word_select),
    .sound_data  (sound_data),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .frame_error (frame_error),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [15:0] l;
    logic [15:0] r;
  } exp_t;

  exp_t   exp_q[$];
  int     compared   = 0;
  int     mismatched = 0;
  longint cyc        = 0;
  longint last_valid = -1;
  bit     period_en  = 1'b0;
  bit     rst_q      = 1'b1;
  logic [15:0] prev_l = '0;
  logic [15:0] prev_r = '0;

  // reference model state
  bit          m_acq;
  bit          m_prev_ws;
  bit          m_pend;
  logic [15:0] m_hold;
  bit          m_bits[$];

  // driver state
  bit cur_ch  = 1'b0;
  int rst_at  = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_acq     = 1'b0;
    m_prev_ws = 1'b0;
    m_pend    = 1'b0;
    m_hold    = '0;
    m_bits.delete();
  endfunction

  // Bits collect into the current channel's word; a WS change closes it
  function automatic void model_bit(input bit ws, input bit sd);
    logic [15:0] v;
    m_bits.push_back(sd);
    if (ws != m_prev_ws) begin
      if (m_acq) begin
        if (m_bits.size() == 16) begin
          v = '0;
          foreach (m_bits[i]) v = {v[14:0], m_bits[i]};
          if (!m_prev_ws) begin
            m_hold = v;
            m_pend = 1'b1;
          end else if (m_pend) begin
            exp_q.push_back('{1'b0, m_hold, v});
            m_pend = 1'b0;
          end
        end else begin
          exp_q.push_back('{1'b1, 16'h0, 16'h0});
          m_pend = 1'b0;
        end
      end
      m_acq     = 1'b1;
      m_prev_ws = ws;
      m_bits.delete();
    end
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_left", 64'(left_sample), 64'h0);
    check("rst_right", 64'(right_sample), 64'h0);
    check("rst_valid", 64'(sample_valid), 64'h0);
    check("rst_error", 64'(frame_error), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
  endtask

  // One BCLK period of 16 clk: data/WS change on the falling edge, sampled on the rise
  task automatic send_bit(input bit ws, input bit sd, input bit do_rst);
    @(posedge clk);
    #2;
    bit_clock   = 1'b0;
    word_select = ws;
    sound_data  = sd;
    repeat (4) @(posedge clk);
    #2 check("locked", 64'(locked), 64'(m_acq));
    if (do_rst) do_reset();
    repeat (4) @(posedge clk);
    #2 bit_clock = 1'b1;
    model_bit(ws, sd);
    repeat (7) @(posedge clk);
  endtask

  // WS switches to the other channel on the word's last bit (one bit ahead of the MSB)
  task automatic send_word(input int len, input logic [63:0] v);
    bit ws;
    for (int i = 0; i < len; i++) begin
      ws = (i == len - 1) ? ~cur_ch : cur_ch;
      send_bit(ws, v[len-1-i], i == rst_at);
    end
    cur_ch = ~cur_ch;
    rst_at = -1;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(16, 64'(l));
    send_word(16, 64'(r));
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_q <= rst;
  end

  // Monitor: pop the scoreboard whenever the DUT strobes, and police output holding
  always @(negedge clk) begin
    exp_t e;
    if (sample_valid || frame_error) begin
      check("strobe_exclusive", 64'(sample_valid & frame_error), 64'h0);
      check("output_expected", 64'(exp_q.size() != 0), 64'h1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_kind", 64'(frame_error), 64'(e.err));
        if (sample_valid && !e.err) begin
          check("left_sample", 64'(left_sample), 64'(e.l));
          check("right_sample", 64'(right_sample), 64'(e.r));
        end
      end
      if (sample_valid && period_en) begin
        if (last_valid >= 0) check("valid_period", 64'(cyc - last_valid), 64'd512);
        last_valid = cyc;
      end
    end
    if (!sample_valid && !rst_q) begin
      check("left_hold", 64'(left_sample), 64'(prev_l));
      check("right_hold", 64'(right_sample), 64'(prev_r));
    end
    prev_l = left_sample;
    prev_r = right_sample;
  end

  initial begin
    int len;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // clean frames; first one only acquires alignment
    repeat (3) send_frame(16'h8001, 16'h7FFE);

    // back-to-back complementary frames
    send_frame(16'hFFFF, 16'h0000);
    send_frame(16'h0000, 16'hFFFF);

    // shortened left word
    send_word(15, 64'h1555);
    send_word(16, 64'h2AAA);
    send_frame(16'hA5C3, 16'h3C5A);

    // WS stuck for 40 BCLKs
    send_word(40, {$urandom, $urandom});
    send_word(16, 64'h0F0F);
    send_frame(16'h1357, 16'h9BDF);
    send_frame(16'h2468, 16'hACE0);

    // reset in the middle of a right word
    send_word(16, 64'h4321);
    rst_at = 8;
    send_word(16, 64'h8765);
    send_frame(16'hCAFE, 16'hBEEF);
    send_frame(16'hDEAD, 16'hF00D);

    // randomized frames with occasional wrong-length words
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 2; c++) begin
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 20)) : 16;
        send_word(len, {$urandom, $urandom});
      end
    end

    // transmitter-style stream: left carries the sample, right is zero
    period_en  = 1'b1;
    last_valid = -1;
    repeat (5) send_frame(16'h1234, 16'h0000);

    repeat (40) @(posedge clk);
    period_en = 1'b0;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
